core_trace_ctrl: RTL and testbench

Synthesizable run controller and write-back trace capture for the pipelined MIPS core (pipemips). It sequences the core's reset release and injects a programmable stall window. It also time-stamps every change on the core's writedata with a cycle count and buffers the samples in a FIFO drained over a valid/ready port. It ends the run after a fixed cycle budget, so the same bring-up flow works on FPGA and in simulation.

---
 rtl/core_trace_ctrl_pkg.sv | 13 +
 rtl/core_trace_ctrl_fifo.sv | 37 +++
 rtl/core_trace_ctrl.sv | 79 +++++++
 tb/tb_core_trace_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/core_trace_ctrl_pkg.sv
// core_trace_pkg: shared run-state encoding, default sizing and trace entry layout.
package core_trace_pkg;
  localparam int DATA_W_D = 32;
  localparam int CNT_W_D = 16;
  localparam int DEPTH_D = 8;
  localparam int RST_HOLD_D = 2;
  localparam int MAX_CYCLES_D = 40;
  typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic [DATA_W_D-1:0] data;
    logic [CNT_W_D-1:0]  cycle;
  } trace_entry_t;
endpackage

// File: rtl/core_trace_ctrl_fifo.sv
// trace_fifo: first-word-fall-through sync FIFO with occupancy; push while full is honoured only alongside a pop.
module trace_fifo #(
  parameter int W = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign dout = mem[rptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wr ? wptr + AW'(1) : wptr;
      rptr <= rd ? rptr + AW'(1) : rptr;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
endmodule

// File: rtl/core_trace_ctrl.sv
// core_trace_ctrl: sequences core reset release, injects a stall window and
// time-stamps every write-back data change into a drainable trace FIFO.
module core_trace_ctrl
  import core_trace_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int CNT_W = CNT_W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int RST_HOLD = RST_HOLD_D,
  parameter int MAX_CYCLES = MAX_CYCLES_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_en,
  input  logic [CNT_W-1:0]         stall_start,
  input  logic [CNT_W-1:0]         stall_len,
  input  logic [DATA_W-1:0]        core_writedata,
  output logic                     core_rst,
  output logic                     core_stall,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [DATA_W-1:0]        trace_data,
  output logic [CNT_W-1:0]         trace_cycle,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic                     done
);
  state_t state;
  logic [CNT_W-1:0] hold_cnt;
  logic [DATA_W-1:0] prev;
  logic prev_valid, run, in_win, cap, push, pop, full, empty;
  logic [DATA_W+CNT_W-1:0] head;
  assign run = state == RUN;
  // window end is formed one bit wider so start+len never wraps back into range
  assign in_win = stall_en && cycle_cnt >= stall_start &&
                  {1'b0, cycle_cnt} < {1'b0, stall_start} + {1'b0, stall_len};
  assign core_stall = done || (run && in_win);
  assign core_rst = state != HOLD;
  assign done = state == DONE;
  assign cap = run && !in_win;
  assign push = cap && (!prev_valid || core_writedata != prev);
  assign pop = trace_valid && trace_ready;
  assign trace_valid = !empty;
  assign {trace_data, trace_cycle} = empty ? '0 : head;
  trace_fifo #(.W(DATA_W + CNT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({core_writedata, cycle_cnt}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(trace_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= HOLD;
      hold_cnt <= '0;
      cycle_cnt <= '0;
      prev <= '0;
      prev_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | (push && full && !pop);
      if (cap) begin
        prev <= core_writedata;
        prev_valid <= 1'b1;
      end
      if (state == HOLD) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
        if (hold_cnt == CNT_W'(RST_HOLD - 1)) state <= RUN;
      end else if (run) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (cycle_cnt == CNT_W'(MAX_CYCLES - 1)) state <= DONE;
      end
    end
endmodule

// File: tb/tb_core_trace_ctrl.sv
// tb_core_trace_ctrl: randomized runs against a cycle-level reference model with a pop-side scoreboard.
module tb_core_trace_ctrl;
  import core_trace_pkg::*;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int DEPTH = 8;
  localparam int HOLDC = 2;
  localparam int MAXC = 40;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall_en = 1'b0;
  logic [CW-1:0] stall_start = '0;
  logic [CW-1:0] stall_len = '0;
  logic [DW-1:0] core_writedata = '0;
  logic trace_ready = 1'b0;
  logic core_rst, core_stall, trace_valid, overflow, done;
  logic [CW-1:0] cycle_cnt, trace_cycle;
  logic [DW-1:0] trace_data;
  logic [$clog2(DEPTH):0] trace_count;
  int checks = 0;
  int errors = 0;
  trace_entry_t exp_q[$];
  int occ;
  bit ovf;

  core_trace_ctrl dut (
    .clk(clk), .rst(rst), .stall_en(stall_en), .stall_start(stall_start),
    .stall_len(stall_len), .core_writedata(core_writedata), .core_rst(core_rst),
    .core_stall(core_stall), .cycle_cnt(cycle_cnt), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data), .trace_cycle(trace_cycle),
    .trace_count(trace_count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // scoreboard side: every accepted handshake must match the oldest expected sample
  always @(negedge clk) begin
    #2;
    if (rst && trace_valid && trace_ready) begin
      trace_entry_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual data=%0d cycle=%0d required none", trace_data, trace_cycle);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", trace_data, e.data);
        chk("pop_cycle", trace_cycle, e.cycle);
      end
    end
  end

  task automatic assert_reset();
    rst = 1'b0;
    #1;
    chk("rst_core_rst", core_rst, 0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_data", trace_data, 0);
    chk("rst_cycle", trace_cycle, 0);
    chk("rst_count", trace_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", done, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    exp_q.delete();
    occ = 0;
    ovf = 0;
  endtask

  function automatic logic [DW-1:0] pick_data(int mode, int k);
    if (mode == 0) return k == 2 ? DW'(7) : k < 2 ? DW'(5) : DW'($urandom_range(0, 3));
    if (mode == 1) return DW'(100 + k);
    return DW'($urandom);
  endfunction

  function automatic logic pick_ready(int mode, int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return k >= 9;
    return 1'b1 & $urandom_range(0, 1);
  endfunction

  task automatic run(input bit en, input int st, input int ln, input int dmode, input int rmode, input int abort_at);
    bit pv, stl, push, pop;
    logic [DW-1:0] prev;
    pv = 0;
    prev = '0;
    @(negedge clk);
    stall_en = en;
    stall_start = CW'(st);
    stall_len = CW'(ln);
    trace_ready = 1'b0;
    assert_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int h = 0; h < HOLDC; h++) begin
      core_writedata = DW'($urandom);
      #1;
      chk("hold_core_rst", core_rst, 0);
      chk("hold_stall", core_stall, 0);
      chk("hold_valid", trace_valid, 0);
      @(negedge clk);
    end
    for (int k = 0; k < MAXC; k++) begin
      if (k == abort_at) begin
        assert_reset();
        return;
      end
      core_writedata = pick_data(dmode, k);
      trace_ready = pick_ready(rmode, k);
      #1;
      stl = en && k >= st && k < st + ln;
      chk("run_cycle_cnt", cycle_cnt, k);
      chk("run_core_rst", core_rst, 1);
      chk("run_done", done, 0);
      chk("run_stall", core_stall, stl);
      chk("run_count", trace_count, occ);
      chk("run_overflow", overflow, ovf);
      pop = occ > 0 && trace_ready;
      push = !stl && (!pv || core_writedata != prev);
      if (!stl) begin
        prev = core_writedata;
        pv = 1;
      end
      if (push) begin
        if (occ < DEPTH || pop) begin
          exp_q.push_back('{data: core_writedata, cycle: CW'(k)});
          occ++;
        end else ovf = 1;
      end
      if (pop) occ--;
      @(negedge clk);
    end
    for (int d = 0; d < DEPTH + 4; d++) begin
      core_writedata = DW'($urandom);
      trace_ready = 1'b1;
      #1;
      chk("done_flag", done, 1);
      chk("done_stall", core_stall, 1);
      chk("done_core_rst", core_rst, 1);
      chk("done_cycle_cnt", cycle_cnt, MAXC);
      chk("done_count", trace_count, occ);
      chk("done_overflow", overflow, ovf);
      if (occ > 0) occ--;
      @(negedge clk);
    end
    #3;
    chk("drained_queue", exp_q.size(), 0);
    chk("drained_valid", trace_valid, 0);
  endtask

  initial begin
    occ = 0;
    ovf = 0;
    run(0, 0, 0, 0, 0, -1);
    run(1, 10, 3, 1, 0, -1);
    run(0, 0, 0, 1, 1, -1);
    run(1, 30, 16'hFFFF, 2, 2, -1);
    run(1, 5, 4, 0, 2, 20);
    run(0, 0, 0, 1, 2, -1);
    for (int r = 0; r < 6; r++)
      run(1'b1 & $urandom_range(0, 1), $urandom_range(0, 45), $urandom_range(0, 12),
          $urandom_range(0, 2), $urandom_range(0, 2), -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
